// File: rtl/gate_pkg.sv
// Shared types, output-decode constants and width helpers for the parametrised
// parking-gate PIN controller.
package gate_pkg;

   typedef enum logic [3:0] {
      CLOSED  = 4'b0001,
      OPEN    = 4'b0010,
      LOCKOUT = 4'b0100,
      BLOCKED = 4'b1000
   } gate_state_e;

   typedef struct packed {
      logic cerrado;
      logic abierto;
      logic alarma;
      logic bloqueo;
   } gate_out_t;

   localparam gate_out_t OUT_CLOSED  = 4'b1000;
   localparam gate_out_t OUT_OPEN    = 4'b0100;
   localparam gate_out_t OUT_LOCKOUT = 4'b1010;
   localparam gate_out_t OUT_BLOCKED = 4'b0011;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int cnt_width(input int max_tries);
      return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
   endfunction

   // A zero-width timer is illegal, so both-disabled still gets one bit.
   function automatic int tmr_width(input int open_timeout, input int lock_cycles);
      int w;
      w = $clog2(max_int(open_timeout, lock_cycles) + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // In OPEN the alarm follows the held-open flag; elsewhere it is fixed per state.
   function automatic gate_out_t decode_out(input gate_state_e s, input logic timeout);
      gate_out_t o;
      case (s)
         OPEN: begin
            o        = OUT_OPEN;
            o.alarma = timeout;
         end
         LOCKOUT: o = OUT_LOCKOUT;
         BLOCKED: o = OUT_BLOCKED;
         default: o = OUT_CLOSED;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/gate_sat_timer.sv
// Saturating up-counter shared by the OPEN hold timer and the LOCKOUT release timer.
module gate_sat_timer #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge Clk) begin
      if (clr) begin
         count <= '0;
      end else if (en && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/gate_controller_param.sv
// Parametrised parking-gate PIN controller: PIN check, failed-attempt lockout,
// tailgate block, held-open alarm and optional timed lockout release.
module gate_controller_param
   import gate_pkg::*;
#(
   parameter int               PIN_W        = 8,
   parameter logic [PIN_W-1:0] PIN_CORRECT  = PIN_W'('h10),
   parameter int               MAX_TRIES    = 3,
   parameter int               OPEN_TIMEOUT = 16,
   parameter int               LOCK_CYCLES  = 0,
   localparam int              CNT_W        = cnt_width(MAX_TRIES)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Vehiculo,
   input  logic             Termino,
   input  logic             enterPin,
   input  logic [PIN_W-1:0] Pin,
   output logic             Cerrado,
   output logic             Abierto,
   output logic             Alarma,
   output logic             Bloqueo,
   output logic [CNT_W-1:0] Intentos,
   output logic             Timeout
);

   localparam int             TW       = tmr_width(OPEN_TIMEOUT, LOCK_CYCLES);
   localparam logic [TW-1:0]  OPEN_END = (OPEN_TIMEOUT > 0) ? TW'(OPEN_TIMEOUT - 1) : '0;
   localparam logic [TW-1:0]  LOCK_END = (LOCK_CYCLES > 0)  ? TW'(LOCK_CYCLES - 1)  : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TRIES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_TRIES - 1);

   gate_state_e      state_q;
   gate_state_e      state_n;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_n;
   logic             timeout_q;
   logic             timeout_n;
   logic [TW-1:0]    timer;
   logic             timer_clr;
   logic             timer_en;
   logic             pin_ok;
   gate_out_t        out_n;

   assign pin_ok = enterPin && (Pin == PIN_CORRECT);

   always_comb begin
      state_n = state_q;
      count_n = count_q;
      case (state_q)
         CLOSED: begin
            if (Vehiculo && enterPin) begin
               if (Pin == PIN_CORRECT) begin
                  state_n = OPEN;
                  count_n = '0;
               end else if (count_q == CNT_LAST) begin
                  state_n = LOCKOUT;
                  count_n = CNT_MAX;
               end else begin
                  count_n = count_q + CNT_W'(1);
               end
            end
         end
         LOCKOUT: begin
            // A correct PIN takes priority over the release on the expiry cycle.
            if (pin_ok) begin
               state_n = OPEN;
               count_n = '0;
            end else if ((LOCK_CYCLES > 0) && (timer == LOCK_END)) begin
               state_n = CLOSED;
               count_n = '0;
            end
         end
         OPEN: begin
            if (Termino) begin
               state_n = Vehiculo ? BLOCKED : CLOSED;
            end
         end
         BLOCKED: begin
            if (pin_ok) begin
               state_n = OPEN;
            end
         end
         default: begin
            state_n = CLOSED;
            count_n = '0;
         end
      endcase
   end

   assign timer_en  = (state_q == OPEN) || (state_q == LOCKOUT);
   assign timer_clr = Reset || (state_n != state_q);

   gate_sat_timer #(
      .WIDTH (TW)
   ) u_timer (
      .Clk   (Clk),
      .clr   (timer_clr),
      .en    (timer_en),
      .count (timer)
   );

   // Flag is set on the edge that takes the timer to OPEN_TIMEOUT and held until OPEN is left.
   assign timeout_n = (OPEN_TIMEOUT > 0) && (state_q == OPEN) && (state_n == OPEN) &&
                      (timeout_q || (timer == OPEN_END));

   assign out_n = decode_out(state_n, timeout_n);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= CLOSED;
         count_q   <= '0;
         timeout_q <= 1'b0;
         Cerrado   <= 1'b1;
         Abierto   <= 1'b0;
         Alarma    <= 1'b0;
         Bloqueo   <= 1'b0;
      end else begin
         state_q   <= state_n;
         count_q   <= count_n;
         timeout_q <= timeout_n;
         Cerrado   <= out_n.cerrado;
         Abierto   <= out_n.abierto;
         Alarma    <= out_n.alarma;
         Bloqueo   <= out_n.bloqueo;
      end
   end

   assign Intentos = count_q;
   assign Timeout  = timeout_q;

endmodule

// File: tb/tb_gate_controller_param.sv
// Directed scoreboard bench for gate_controller_param with OPEN_TIMEOUT=16, LOCK_CYCLES=8.
module tb_gate_controller_param;

   logic       Clk = 1'b0;
   logic       Reset, Vehiculo, Termino, enterPin;
   logic [7:0] Pin;
   logic       Cerrado, Abierto, Alarma, Bloqueo, Timeout;
   logic [1:0] Intentos;

   logic [6:0] exp_q[$];
   string      tag_q[$];
   int         tests = 0;
   int         fails = 0;

   always #5 Clk = ~Clk;

   gate_controller_param #(
      .PIN_W        (8),
      .PIN_CORRECT  (8'h10),
      .MAX_TRIES    (3),
      .OPEN_TIMEOUT (16),
      .LOCK_CYCLES  (8)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Vehiculo (Vehiculo),
      .Termino  (Termino),
      .enterPin (enterPin),
      .Pin      (Pin),
      .Cerrado  (Cerrado),
      .Abierto  (Abierto),
      .Alarma   (Alarma),
      .Bloqueo  (Bloqueo),
      .Intentos (Intentos),
      .Timeout  (Timeout)
   );

   // Expected vector layout: {Cerrado, Abierto, Alarma, Bloqueo, Intentos[1:0], Timeout}
   function automatic logic [6:0] closed_exp(input logic [1:0] n);
      return {4'b1000, n, 1'b0};
   endfunction
   localparam logic [6:0] E_OPEN    = {4'b0100, 2'd0, 1'b0};
   localparam logic [6:0] E_OPEN_TO = {4'b0110, 2'd0, 1'b1};
   localparam logic [6:0] E_LOCK    = {4'b1010, 2'd3, 1'b0};
   localparam logic [6:0] E_BLOCKED = {4'b0011, 2'd0, 1'b0};

   function automatic logic [7:0] wrong_pin();
      logic [7:0] p;
      p = 8'($urandom_range(0, 255));
      if (p == 8'h10) p = 8'h11;
      return p;
   endfunction

   task automatic check_out();
      logic [6:0] e;
      logic [6:0] obs;
      string      t;
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {Cerrado, Abierto, Alarma, Bloqueo, Intentos, Timeout};
      tests++;
      assert (obs === e) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", t, obs, e);
      end
   endtask

   task automatic step(input logic rst, input logic v, input logic t, input logic e,
                       input logic [7:0] pin, input logic [6:0] exp, input string tag);
      Reset    = rst;
      Vehiculo = v;
      Termino  = t;
      enterPin = e;
      Pin      = pin;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge Clk);
      #1;
      check_out();
   endtask

   initial begin
      step(1, 0, 0, 0, 8'h00, closed_exp(0), "reset");

      step(0, 1, 0, 1, 8'h10, E_OPEN,        "pin_ok_open");
      step(0, 0, 1, 0, 8'h00, closed_exp(0), "termino_close");

      step(0, 1, 0, 1, 8'h11,       closed_exp(1), "wrong1");
      step(0, 1, 0, 1, wrong_pin(), closed_exp(2), "wrong2");
      step(0, 1, 0, 1, 8'h11,       E_LOCK,        "wrong3_lockout");
      step(0, 1, 0, 1, wrong_pin(), E_LOCK,        "wrong4_saturate");
      step(0, 1, 0, 1, 8'h10,       E_OPEN,        "lockout_pin_ok");

      step(0, 1, 1, 0, 8'h00,       E_BLOCKED, "tailgate");
      step(0, 1, 0, 1, wrong_pin(), E_BLOCKED, "blocked_wrong");
      step(0, 0, 0, 0, 8'h00,       E_BLOCKED, "blocked_idle");
      step(0, 0, 0, 1, 8'h10,       E_OPEN,    "blocked_pin_ok");

      for (int k = 1; k <= 15; k++) begin
         step(0, 1, 0, (k == 5), 8'h10, E_OPEN, $sformatf("open_hold_%0d", k));
      end
      for (int k = 16; k <= 18; k++) begin
         step(0, 1, 0, 0, 8'h00, E_OPEN_TO, $sformatf("open_timeout_%0d", k));
      end
      step(0, 0, 1, 1, 8'h10, closed_exp(0), "timeout_exit_pin_dropped");

      step(0, 1, 0, 1, wrong_pin(), closed_exp(1), "auto_w1");
      step(0, 1, 0, 1, wrong_pin(), closed_exp(2), "auto_w2");
      step(0, 1, 0, 1, wrong_pin(), E_LOCK,        "auto_w3");
      for (int k = 1; k <= 7; k++) begin
         step(0, 0, 0, 0, 8'h00, E_LOCK, $sformatf("lock_wait_%0d", k));
      end
      step(0, 0, 0, 0, 8'h00, closed_exp(0), "lock_release_8");

      step(0, 1, 0, 1, wrong_pin(), closed_exp(1), "exp_w1");
      step(0, 1, 0, 1, wrong_pin(), closed_exp(2), "exp_w2");
      step(0, 1, 0, 1, wrong_pin(), E_LOCK,        "exp_w3");
      for (int k = 1; k <= 7; k++) begin
         step(0, 0, 0, 0, 8'h00, E_LOCK, $sformatf("exp_wait_%0d", k));
      end
      step(0, 1, 0, 1, 8'h10, E_OPEN,        "pin_on_expiry");
      step(0, 0, 1, 0, 8'h00, closed_exp(0), "exp_exit");

      step(0, 1, 0, 1, 8'h10, E_OPEN,        "rb_open");
      step(0, 1, 1, 0, 8'h00, E_BLOCKED,     "rb_blocked");
      step(1, 1, 0, 1, 8'h10, closed_exp(0), "reset_in_blocked");

      step(0, 1, 0, 1, wrong_pin(), closed_exp(1), "rc_w1");
      step(0, 1, 0, 1, wrong_pin(), closed_exp(2), "rc_w2");
      step(1, 1, 0, 1, wrong_pin(), closed_exp(0), "reset_mid_count");

      step(0, 0, 0, 1, 8'h10,       closed_exp(0), "pin_ok_no_vehicle");
      step(0, 0, 0, 1, wrong_pin(), closed_exp(0), "pin_bad_no_vehicle");
      step(0, 1, 0, 1, 8'h10,       E_OPEN,        "final_open");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
